// File: rtl/ultra_sonic_pkg.sv
// Shared types and channel-selection helper for the multi-channel ultrasonic ranger.
package ultra_sonic_pkg;

    localparam int unsigned US_MAX_CH      = 16;
    localparam int unsigned US_MAX_CH_W    = 4;
    localparam int unsigned US_MAX_COUNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT_ECHO,
        ST_ON_ECHO,
        ST_REPORT,
        ST_HOLDOFF
    } us_state_t;

    // Fields are sized for the largest legal configuration; the top narrows them.
    typedef struct packed {
        logic [US_MAX_COUNT_W-1:0] count;
        logic [US_MAX_CH_W-1:0]    ch;
        logic                      timeout;
    } us_result_t;

    typedef struct packed {
        logic [US_MAX_CH_W-1:0] ch;
        logic                   wrap;
    } us_next_t;

    // Lowest enabled channel above cur; otherwise the lowest enabled channel with wrap=1.
    function automatic us_next_t next_enabled(input logic [US_MAX_CH-1:0] mask,
                                              input logic [US_MAX_CH_W-1:0] cur);
        us_next_t r;
        logic     found;
        r.ch   = '0;
        r.wrap = 1'b1;
        found  = 1'b0;
        for (int i = US_MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.ch  = US_MAX_CH_W'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = US_MAX_CH - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    r.ch = US_MAX_CH_W'(i);
                end
            end
        end
        r.wrap = !found;
        return r;
    endfunction

endpackage

// File: rtl/ultra_sonic_array_echo_sync_edge.sv
// Two-flop synchronizer for one echo line plus rise/fall detection on the synced level.
module echo_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultra_sonic_array.sv
// Round-robin sequencer for N_CH ultrasonic rangers sharing one timer; results leave over
// valid/ready: result_* are held stable while result_valid=1 and transfer on result_ready=1.
module ultra_sonic_array
    import ultra_sonic_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned COUNT_WIDTH    = 23,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1900000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    localparam int unsigned CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_all,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic [N_CH-1:0]        echo_in,
    output logic [N_CH-1:0]        trig_out,
    output logic [COUNT_WIDTH-1:0] result_count,
    output logic [CH_W-1:0]        result_ch,
    output logic                   result_timeout,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   active_out,
    output us_state_t              dbg_state_o
);

    if (N_CH < 1 || N_CH > US_MAX_CH) begin : g_bad_n_ch
        $error("ultra_sonic_array: N_CH must be 1..16");
    end
    if (COUNT_WIDTH > US_MAX_COUNT_W) begin : g_bad_count_width
        $error("ultra_sonic_array: COUNT_WIDTH must be <= 32");
    end
    if (64'(TIMEOUT_CYCLES) >= (64'd1 << COUNT_WIDTH) ||
        64'(HOLDOFF_CYCLES) >= (64'd1 << COUNT_WIDTH) ||
        64'(TRIG_CYCLES) >= (64'd1 << COUNT_WIDTH)) begin : g_bad_cycles
        $error("ultra_sonic_array: cycle parameters must fit in COUNT_WIDTH");
    end
    if (TIMEOUT_CYCLES == 0 || HOLDOFF_CYCLES == 0 || TRIG_CYCLES == 0) begin : g_zero_cycles
        $error("ultra_sonic_array: cycle parameters must be non-zero");
    end

    localparam logic [COUNT_WIDTH-1:0] TRIG_LAST    = COUNT_WIDTH'(TRIG_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST    = COUNT_WIDTH'(HOLDOFF_CYCLES - 1);

    us_state_t              state_q, state_d;
    logic [COUNT_WIDTH-1:0] timer_q, timer_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [N_CH-1:0]        mask_q, mask_d;
    logic [N_CH-1:0]        trig_q, trig_d;
    us_result_t             result_q, result_d;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] ch_sel;
    logic            rise_sel;
    logic            fall_sel;
    us_next_t        nxt;
    us_next_t        first;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        echo_sync_edge u_sync (
            .clk    (clk),
            .rst_n  (reset_all),
            .echo_i (echo_in[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g])
        );
    end

    assign ch_sel   = N_CH'(1) << ch_q;
    assign rise_sel = |(rise & ch_sel);
    assign fall_sel = |(fall & ch_sel);
    assign nxt      = next_enabled(US_MAX_CH'(mask_q), US_MAX_CH_W'(ch_q));
    assign first    = next_enabled(US_MAX_CH'(ch_mask), {US_MAX_CH_W{1'b1}});

    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            ch_q     <= '0;
            mask_q   <= '0;
            trig_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ch_q     <= ch_d;
            mask_q   <= mask_d;
            trig_q   <= trig_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ch_d     = ch_q;
        mask_d   = mask_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    ch_d    = CH_W'(first.ch);
                    timer_d = '0;
                    state_d = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                if (timer_q == TRIG_LAST) begin
                    timer_d = '0;
                    state_d = ST_WAIT_ECHO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_ECHO: begin
                // The rise cycle is itself an echo-high cycle, so counting starts at 1.
                if (rise_sel) begin
                    timer_d = COUNT_WIDTH'(1);
                    state_d = ST_ON_ECHO;
                end else if (timer_q == TIMEOUT_LAST) begin
                    result_d.count   = '0;
                    result_d.ch      = US_MAX_CH_W'(ch_q);
                    result_d.timeout = 1'b1;
                    state_d          = ST_REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ON_ECHO: begin
                if (fall_sel) begin
                    result_d.count   = US_MAX_COUNT_W'(timer_q);
                    result_d.ch      = US_MAX_CH_W'(ch_q);
                    result_d.timeout = 1'b0;
                    state_d          = ST_REPORT;
                end else if (timer_q == TIMEOUT_LAST) begin
                    result_d.count   = US_MAX_COUNT_W'(TIMEOUT_CYCLES);
                    result_d.ch      = US_MAX_CH_W'(ch_q);
                    result_d.timeout = 1'b1;
                    state_d          = ST_REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    timer_d = '0;
                    state_d = (!nxt.wrap || continuous) ? ST_HOLDOFF : ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == HOLD_LAST) begin
                    timer_d = '0;
                    if (!nxt.wrap) begin
                        ch_d    = CH_W'(nxt.ch);
                        state_d = ST_TRIGGER;
                    end else begin
                        // Wrapping only happens in continuous mode: pick up the live mask.
                        mask_d = ch_mask;
                        if (|ch_mask) begin
                            ch_d    = CH_W'(first.ch);
                            state_d = ST_TRIGGER;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        trig_d = (state_d == ST_TRIGGER) ? (N_CH'(1) << ch_d) : '0;
    end

    assign trig_out       = trig_q;
    assign result_count   = COUNT_WIDTH'(result_q.count);
    assign result_ch      = CH_W'(result_q.ch);
    assign result_timeout = result_q.timeout;
    assign result_valid   = (state_q == ST_REPORT);
    assign active_out     = (state_q != ST_IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ultra_sonic_array.sv
// Directed bench for ultra_sonic_array with short trigger/timeout/holdoff windows.
module tb_ultra_sonic_array;
    import ultra_sonic_pkg::*;

    localparam int TRIG    = 4;
    localparam int TIMEOUT = 100;
    localparam int HOLD    = 10;

    logic        clk;
    logic        reset_all;
    logic        start;
    logic        continuous;
    logic [3:0]  ch_mask;
    logic [3:0]  echo_in;
    logic [3:0]  trig_out;
    logic [22:0] result_count;
    logic [1:0]  result_ch;
    logic        result_timeout;
    logic        result_valid;
    logic        result_ready;
    logic        active_out;
    us_state_t   dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    us_result_t exp_q[$];

    typedef struct {
        logic [3:0] mask;
        int         ch;
        int         delay;
        int         width;
        int         exp_count;
        logic       exp_to;
    } vec_t;

    vec_t vecs[6];

    ultra_sonic_array #(
        .N_CH           (4),
        .COUNT_WIDTH    (23),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .reset_all      (reset_all),
        .start          (start),
        .continuous     (continuous),
        .ch_mask        (ch_mask),
        .echo_in        (echo_in),
        .trig_out       (trig_out),
        .result_count   (result_count),
        .result_ch      (result_ch),
        .result_timeout (result_timeout),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .active_out     (active_out),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for the trigger, checks which channel fired and for how long; returns at
    // the first cycle with the trigger low.
    task automatic wait_trig(input int ch, input string tag);
        int n;
        int hi;
        logic [3:0] oh;
        n  = 0;
        hi = 0;
        oh = 4'b0001 << ch;
        while (trig_out == 4'b0000 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_trig_sel"}, 64'(trig_out), 64'(oh));
        while (trig_out != 4'b0000 && hi < 50) begin
            hi++;
            tick();
        end
        check({tag, "_trig_len"}, 64'(hi), 64'(TRIG));
    endtask

    task automatic drive_echo(input int ch, input int delay, input int width);
        if (width > 0) begin
            repeat (delay) tick();
            echo_in[ch] = 1'b1;
            repeat (width) tick();
            echo_in[ch] = 1'b0;
        end
    endtask

    task automatic push_exp(input int ch, input int count, input logic to);
        us_result_t r;
        r.count   = 32'(count);
        r.ch      = 4'(ch);
        r.timeout = to;
        exp_q.push_back(r);
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_result(input string tag);
        us_result_t e;
        int n;
        n = 0;
        e = exp_q.pop_front();
        while (!result_valid && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(result_valid), 64'd1);
        check({tag, "_ch"}, 64'(result_ch), 64'(e.ch));
        check({tag, "_count"}, 64'(result_count), 64'(e.count));
        check({tag, "_timeout"}, 64'(result_timeout), 64'(e.timeout));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
    endtask

    // Counts trigger-low cycles from the accept until the next trigger appears.
    task automatic check_gap(input string tag);
        int gap;
        gap = 0;
        while (trig_out == 4'b0000 && gap < 60) begin
            gap++;
            tick();
        end
        check({tag, "_gap"}, 64'(gap), 64'(HOLD));
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        int seen;
        vecs[0] = '{mask: 4'b0001, ch: 0, delay: 5,  width: 1,   exp_count: 1,   exp_to: 1'b0};
        vecs[1] = '{mask: 4'b0100, ch: 2, delay: 10, width: 55,  exp_count: 55,  exp_to: 1'b0};
        vecs[2] = '{mask: 4'b1000, ch: 3, delay: 2,  width: 99,  exp_count: 99,  exp_to: 1'b0};
        vecs[3] = '{mask: 4'b0010, ch: 1, delay: 0,  width: 150, exp_count: 100, exp_to: 1'b1};
        vecs[4] = '{mask: 4'b0001, ch: 0, delay: 0,  width: 0,   exp_count: 0,   exp_to: 1'b1};
        vecs[5] = '{mask: 4'b1000, ch: 3, delay: 80, width: 20,  exp_count: 20,  exp_to: 1'b0};

        reset_all    = 1'b0;
        start        = 1'b0;
        continuous   = 1'b0;
        ch_mask      = 4'b0000;
        echo_in      = 4'b0000;
        result_ready = 1'b0;
        repeat (3) tick();
        check("rst_trig", 64'(trig_out), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_count", 64'(result_count), 64'd0);
        check("rst_ch", 64'(result_ch), 64'd0);
        check("rst_timeout", 64'(result_timeout), 64'd0);
        check("rst_active", 64'(active_out), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        reset_all = 1'b1;
        repeat (2) tick();

        // start with an empty mask is ignored
        pulse_start();
        tick();
        check("zero_mask_active", 64'(active_out), 64'd0);

        // single-channel measurements from the table
        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            ch_mask = vecs[i].mask;
            pulse_start();
            wait_trig(vecs[i].ch, tag);
            push_exp(vecs[i].ch, vecs[i].exp_count, vecs[i].exp_to);
            drive_echo(vecs[i].ch, vecs[i].delay, vecs[i].width);
            expect_result(tag);
            check({tag, "_idle"}, 64'(active_out), 64'd0);
        end

        // single sweep over channels 0 and 2
        ch_mask = 4'b0101;
        pulse_start();
        wait_trig(0, "sweep0");
        push_exp(0, 37, 1'b0);
        drive_echo(0, 5, 37);
        expect_result("sweep0");
        check_gap("sweep2");
        wait_trig(2, "sweep2");
        push_exp(2, 12, 1'b0);
        drive_echo(2, 7, 12);
        expect_result("sweep2");
        check("sweep_idle", 64'(active_out), 64'd0);
        check("sweep_state", 64'(dbg_state), 64'(ST_IDLE));

        // no echo: timeout reported exactly TIMEOUT cycles after the trigger falls
        ch_mask = 4'b0010;
        pulse_start();
        wait_trig(1, "noecho");
        n = 0;
        while (!result_valid && n < 300) begin
            n++;
            tick();
        end
        check("noecho_latency", 64'(n), 64'(TIMEOUT));
        push_exp(1, 0, 1'b1);
        expect_result("noecho");

        // stuck echo, then a trigger with echo already high must not measure
        ch_mask = 4'b1000;
        pulse_start();
        wait_trig(3, "stuck");
        repeat (3) tick();
        echo_in[3] = 1'b1;
        push_exp(3, 100, 1'b1);
        expect_result("stuck");
        pulse_start();
        wait_trig(3, "prehigh");
        push_exp(3, 0, 1'b1);
        expect_result("prehigh");
        echo_in[3] = 1'b0;
        repeat (3) tick();

        // backpressure: result held, no triggers, holdoff counted from accept
        ch_mask = 4'b0011;
        pulse_start();
        wait_trig(0, "bp0");
        drive_echo(0, 3, 20);
        n = 0;
        while (!result_valid && n < 300) begin
            n++;
            tick();
        end
        for (int k = 0; k < 50; k++) begin
            if (k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            echo_in[0] = k[2];
            check("bp_valid", 64'(result_valid), 64'd1);
            check("bp_count", 64'(result_count), 64'd20);
            check("bp_trig", 64'(trig_out), 64'd0);
            tick();
        end
        echo_in[0] = 1'b0;
        push_exp(0, 20, 1'b0);
        expect_result("bp0");
        check_gap("bp1");
        wait_trig(1, "bp1");
        push_exp(1, 8, 1'b0);
        drive_echo(1, 4, 8);
        expect_result("bp1");
        check("bp_idle", 64'(active_out), 64'd0);

        // continuous wrap over channels 0 and 3, then an empty mask stops at the wrap
        ch_mask    = 4'b1001;
        continuous = 1'b1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            string tag;
            int ch;
            tag = $sformatf("cont%0d", k);
            ch  = (k % 2 == 1) ? 3 : 0;
            if (k > 0) check_gap(tag);
            wait_trig(ch, tag);
            push_exp(ch, 5 + k, 1'b0);
            drive_echo(ch, 4, 5 + k);
            if (k == 3) ch_mask = 4'b0000;
            expect_result(tag);
        end
        n    = 0;
        seen = 0;
        while (active_out && n < 40) begin
            if (trig_out != 4'b0000) seen = 1;
            n++;
            tick();
        end
        check("cont_stop_active", 64'(active_out), 64'd0);
        check("cont_stop_trig", 64'(seen), 64'd0);
        check("cont_stop_len", 64'(n), 64'(HOLD));
        continuous = 1'b0;

        // asynchronous reset during the trigger pulse
        ch_mask = 4'b0110;
        pulse_start();
        check("rstmid_trig_on", 64'(trig_out), 64'b0010);
        #2;
        reset_all = 1'b0;
        #1;
        check("rstmid_trig", 64'(trig_out), 64'd0);
        check("rstmid_valid", 64'(result_valid), 64'd0);
        check("rstmid_active", 64'(active_out), 64'd0);
        tick();
        reset_all = 1'b1;
        repeat (2) tick();
        pulse_start();
        wait_trig(1, "rstmid_restart");
        push_exp(1, 15, 1'b0);
        drive_echo(1, 6, 15);
        expect_result("rstmid_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ultra_sonic_array.md
Name: ultra_sonic_array

Overview:
Parametrised multi-channel successor to the single-sensor ultrasonic ranger (HC-SR04-class sensors). Sequences N_CH sensors round-robin over the enabled channels. For each channel it issues a trigger pulse and times the echo-high width in clock cycles. Each measurement is reported with channel id and timeout flag over a valid/ready handshake to the downstream distance/display logic.

Parameters:
N_CH, 4, number of sensor channels (1..16)
CH_W, $clog2(N_CH) min 1, channel id width (localparam)
COUNT_WIDTH, 23, echo/timer counter width
TRIG_CYCLES, 500, trigger high width in clk cycles (10 us at 50 MHz)
TIMEOUT_CYCLES, 1900000, max cycles waiting for echo rise or echo high (38 ms)
HOLDOFF_CYCLES, 3000000, quiet gap before each trigger after a report (60 ms)

Ports:
clk  in  1  system clock, 50 MHz
reset_all  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a sweep when idle
continuous  in  1  1 = sweeps repeat forever; 0 = one sweep then idle
ch_mask  in  N_CH  enabled channels; latched at sweep start
echo_in  in  N_CH  raw asynchronous echo lines
trig_out  out  N_CH  per-channel trigger, registered, one-hot or zero
result_count  out  COUNT_WIDTH  echo-high width in cycles
result_ch  out  CH_W  channel of the result
result_timeout  out  1  measurement timed out
result_valid  out  1  result available
result_ready  in  1  consumer accepts the result
active_out  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, mask latch 0, timer 0, current channel 0.
- echo_in passes through a 2-flop synchronizer plus edge detect. All echo decisions use the synced signal. The 2-cycle latency applies equally to both edges, so widths are exact.
- Elaboration assertion: TIMEOUT_CYCLES, HOLDOFF_CYCLES and TRIG_CYCLES are each < 2**COUNT_WIDTH.
- States: IDLE, TRIGGER, WAIT_ECHO, ON_ECHO, REPORT, HOLDOFF.
- IDLE:
  - start=1 with ch_mask!=0: latch mask, select lowest enabled channel, go TRIGGER.
  - start with mask==0: ignored.
  - start outside IDLE: ignored.
- TRIGGER:
  - trig_out[ch]=1 for exactly TRIG_CYCLES cycles, then clear timer and go WAIT_ECHO.
- WAIT_ECHO:
  - Requires a synced rising edge. An echo already high on entry does not count.
  - Rise: clear count, go ON_ECHO.
  - Timer reaches TIMEOUT_CYCLES first: result_timeout=1, result_count=0, go REPORT.
- ON_ECHO:
  - Count increments each cycle synced echo is high.
  - Synced fall: go REPORT with the count and timeout=0.
  - Count reaches TIMEOUT_CYCLES: go REPORT with count=TIMEOUT_CYCLES and timeout=1. The counter never wraps.
- REPORT:
  - result_valid=1; result_* held stable until a cycle with result_ready=1.
  - Echo activity during the stall is ignored.
  - On accept, result_valid drops the next cycle:
    - More enabled channels remain, or continuous=1: go HOLDOFF.
    - Otherwise: go IDLE.
- HOLDOFF:
  - Wait HOLDOFF_CYCLES, then TRIGGER on the next enabled channel above the current one.
  - Wrap to the lowest enabled channel when continuous.
  - With continuous=1, ch_mask is re-latched at each wrap; if the new mask is 0, go IDLE.
- Channel order is ascending in a sweep; disabled channels are skipped with no gap.
- continuous may change at any time; it is sampled on REPORT accept.
- Reset mid-operation: trig_out drops immediately (asynchronously); any pending result is discarded.

Decomposition:
- Package ultra_sonic_pkg: state enum typedef us_state_t; result struct typedef {count, ch, timeout}; helper function next_enabled(mask, cur) returning next channel plus wrap flag.
- Sub-module echo_sync_edge: 2-flop synchronizer with rise/fall outputs, one instance per channel.
- Single shared timer/counter in the top. Only one channel is active at a time.

Test Plan:
Use sim params N_CH=4, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=10.
- Single sweep: mask=4'b0101, continuous=0, start; echo0 high 37 cycles after trigger, echo2 high 12 -> trig_out[0] high 4 cycles; results (ch0, 37, to=0) then (ch2, 12, to=0); 10-cycle gap before trig2; then IDLE, active_out=0.
- No echo: mask=4'b0010, start, echo idle -> result (ch1, count 0, to=1) exactly 100 cycles after trigger falls.
- Stuck echo: echo3 rises and stays high -> result (ch3, 100, to=1); echo3 already high at the next trigger does not start a measurement.
- Backpressure: result_ready=0 for 50 cycles -> result_valid and data stable; no trig_out during the stall; holdoff starts only after accept.
- Continuous wrap: mask=4'b1001, continuous=1 -> channel order 0,3,0,3; clear mask to 0 -> IDLE at the next wrap.
- Reset mid-TRIGGER: assert reset_all during trig_out[0]=1 -> trig_out=0 and result_valid=0 the same cycle; start after release begins a fresh sweep at the lowest enabled channel.
